// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared constants for the UART instruction-memory loader:
//                FSM state encoding, sync byte and length-field width.
//                Optional macro: LOADER_CHECKSUM_EN (adds CHK/ERROR states).
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_W     = 16;
  localparam int         ST_W      = 3;

  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_LEN_LO = 3'd1;
  localparam logic [ST_W-1:0] ST_LEN_HI = 3'd2;
  localparam logic [ST_W-1:0] ST_DATA   = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE   = 3'd5;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [ST_W-1:0] ST_CHK    = 3'd4;
  localparam logic [ST_W-1:0] ST_ERROR  = 3'd6;
`endif

  // True for every state between sync acceptance and a terminal state.
  function automatic logic is_loading(input logic [ST_W-1:0] s);
    logic r;
    r = (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
`ifdef LOADER_CHECKSUM_EN
    r = r || (s == ST_CHK);
`endif
    return r;
  endfunction

endpackage : loader_pkg
`default_nettype wire

// File: rtl/loader_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : loader_uart_rx
//  Description : 8N1 UART receiver. 2-FF synchronizer, falling-edge start
//                detection, mid-bit sampling, LSB first. A byte whose stop
//                bit samples low is dropped silently.
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] C_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] C_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic             r_meta;
  logic             r_sync;
  logic             r_sync_d;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;

  // Synchronize the line, then walk start/data/stop bits sampling at mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta   <= 1'b1;
      r_sync   <= 1'b1;
      r_sync_d <= 1'b1;
      r_state  <= RX_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      r_meta   <= rx;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      rx_valid <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_sync_d && !r_sync) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == C_HALF_M1) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            // A line that bounced back high was a glitch, not a start bit.
            r_state <= r_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        RX_DATA: begin
          if (r_cnt == C_FULL_M1) begin
            r_cnt   <= '0;
            r_shift <= {r_sync, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= RX_STOP;
            r_bit <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
        default: begin
          if (r_cnt == C_FULL_M1) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= r_shift;
            end
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
          end
        end
      endcase
    end
  end

endmodule : loader_uart_rx
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : UART boot loader. Waits for sync byte 0xA5, reads a 16-bit
//                little-endian word count, then writes that many
//                little-endian 32-bit words to instruction memory from
//                address 0 and releases the core reset.
//                Optional macro: LOADER_CHECKSUM_EN - a trailing XOR byte
//                over length+data is verified; mismatch parks in ERROR.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);
  import loader_pkg::*;

  localparam logic [ADDR_W-1:0] C_ADDR_ONE = ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
  localparam logic [ST_W-1:0] C_ST_AFTER = ST_CHK;
`else
  localparam logic [ST_W-1:0] C_ST_AFTER = ST_DONE;
`endif

  logic             w_rx_valid;
  logic [7:0]       w_rx_byte;
  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_next;
  logic [7:0]       r_len_lo;
  logic [LEN_W-1:0] r_remaining;
  logic [1:0]       r_byte_idx;
  logic [23:0]      r_word;

  loader_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (uart_rx),
    .rx_valid (w_rx_valid),
    .rx_byte  (w_rx_byte)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xor;

  // Running XOR over length and payload bytes, restarted on sync.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xor <= '0;
    end else if (w_rx_valid) begin
      if (r_state == ST_IDLE) r_xor <= '0;
      else if (is_loading(r_state) && r_state != ST_CHK) r_xor <= r_xor ^ w_rx_byte;
    end
  end

  // Sticky error flag, set on entry to ERROR.
  always_ff @(posedge clk) begin
    if (rst) load_err <= 1'b0;
    else if (w_next == ST_ERROR) load_err <= 1'b1;
  end
`else
  assign load_err = 1'b0;
`endif

  // Next-state decode: one byte advances the FSM at most one step.
  always_comb begin
    w_next = r_state;
    if (w_rx_valid) begin
      case (r_state)
        ST_IDLE:   if (w_rx_byte == SYNC_BYTE) w_next = ST_LEN_LO;
        ST_LEN_LO: w_next = ST_LEN_HI;
        ST_LEN_HI: w_next = ({w_rx_byte, r_len_lo} == '0) ? C_ST_AFTER : ST_DATA;
        ST_DATA:   if (r_byte_idx == 2'd3 && r_remaining == 16'd1) w_next = C_ST_AFTER;
`ifdef LOADER_CHECKSUM_EN
        ST_CHK:    w_next = (w_rx_byte == r_xor) ? ST_DONE : ST_ERROR;
`endif
        default:   w_next = r_state;
      endcase
    end
  end

  // State, status outputs, word assembly and memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_len_lo    <= '0;
      r_remaining <= '0;
      r_byte_idx  <= '0;
      r_word      <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_rst_n  <= 1'b0;
      busy        <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      r_state    <= w_next;
      busy       <= is_loading(w_next);
      core_rst_n <= (r_state == ST_DONE);
      if (w_next == ST_DONE) load_done <= 1'b1;
      imem_we <= 1'b0;
      if (imem_we) imem_addr <= imem_addr + C_ADDR_ONE;
      if (w_rx_valid) begin
        case (r_state)
          ST_LEN_LO: r_len_lo <= w_rx_byte;
          ST_LEN_HI: begin
            r_remaining <= {w_rx_byte, r_len_lo};
            r_byte_idx  <= '0;
          end
          ST_DATA: begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_word[7:0]   <= w_rx_byte;
              2'd1: r_word[15:8]  <= w_rx_byte;
              2'd2: r_word[23:16] <= w_rx_byte;
              default: begin
                imem_we     <= 1'b1;
                imem_wdata  <= {w_rx_byte, r_word};
                r_remaining <= r_remaining - 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Bytes are serialized
//                onto uart_rx; a behavioural parser of the load protocol
//                predicts writes and final status.
//                Optional macro: LOADER_CHECKSUM_EN (must match the RTL build).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int CLKS = 8;
  localparam int AW   = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          uart_rx = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n, busy, load_done, load_err;

  int errors = 0;
  int checks = 0;

  logic [7:0]    tx_bytes[$];
  bit            tx_bad[$];
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  bit            exp_done, exp_err;

  imem_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst_n(core_rst_n),
    .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Record every memory write, sampled away from the active edge.
  always @(negedge clk) begin
    if (imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  task automatic add(input logic [7:0] b, input bit bad = 1'b0);
    tx_bytes.push_back(b);
    tx_bad.push_back(bad);
  endtask

  // Append the XOR of length+data bytes following the first sync byte.
  task automatic add_chk();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    bit seen = 1'b0;
    foreach (tx_bytes[k]) begin
      if (!tx_bad[k]) begin
        if (seen) x ^= tx_bytes[k];
        else if (tx_bytes[k] == 8'hA5) seen = 1'b1;
      end
    end
    add(x);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    uart_rx = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (CLKS) @(negedge clk);
    end
    uart_rx = bad ? 1'b0 : 1'b1;
    repeat (CLKS) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CLKS) @(negedge clk);
  endtask

  task automatic send_all();
    @(negedge clk);
    foreach (tx_bytes[k]) send_byte(tx_bytes[k], tx_bad[k]);
    repeat (4 * CLKS) @(negedge clk);
  endtask

  // Protocol-level prediction: drop framing errors, find sync, read length,
  // take four bytes per word, then judge the optional checksum.
  task automatic run_model();
    logic [7:0] g[$];
    int i, n;
    int len;
    logic [7:0] x;
    exp_addr.delete(); exp_data.delete();
    exp_done = 1'b0; exp_err = 1'b0;
    foreach (tx_bytes[k]) if (!tx_bad[k]) g.push_back(tx_bytes[k]);
    n = g.size();
    i = 0;
    while (i < n && g[i] != 8'hA5) i++;
    i++;
    if (i + 1 >= n) return;
    len = int'(g[i]) + 256 * int'(g[i+1]);
    x = g[i] ^ g[i+1];
    i += 2;
    for (int w = 0; w < len; w++) begin
      if (i + 3 >= n) return;
      exp_addr.push_back(AW'(w));
      exp_data.push_back({g[i+3], g[i+2], g[i+1], g[i]});
      x ^= g[i] ^ g[i+1] ^ g[i+2] ^ g[i+3];
      i += 4;
    end
`ifdef LOADER_CHECKSUM_EN
    if (i >= n) return;
    if (g[i] == x) exp_done = 1'b1;
    else exp_err = 1'b1;
`else
    exp_done = 1'b1;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got_addr.delete(); got_data.delete();
    tx_bytes.delete(); tx_bad.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({imem_we, imem_addr, imem_wdata, core_rst_n, busy, load_done, load_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%h wd=%h crn=%b busy=%b done=%b err=%b want all 0",
               imem_we, imem_addr, imem_wdata, core_rst_n, busy, load_done, load_err);
    end
  endtask

  task automatic test_a85();
    do_reset();
    add(8'hA5); add(8'h02); add(8'h00);
    add(8'h13); add(8'h00); add(8'h00); add(8'h00);
    add(8'h6F); add(8'h00); add(8'h00); add(8'h00);
`ifdef LOADER_CHECKSUM_EN
    add(8'h7E);
`endif
    run_model();
    send_all();
    checks++;
    if (got_addr.size() != 2) begin
      errors++; $display("FAIL a85_wcount: got %0d want 2", got_addr.size());
    end
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      checks++;
      if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
        errors++;
        $display("FAIL a85_write%0d: got %h@%h want %h@%h", k, got_data[k], got_addr[k], exp_data[k], exp_addr[k]);
      end
    end
    checks++;
    if (got_data.size() > 1 && (got_data[0] !== 32'h00000013 || got_data[1] !== 32'h0000006F)) begin
      errors++; $display("FAIL a85_literal: got %h %h want 00000013 0000006f", got_data[0], got_data[1]);
    end
    checks++;
    if ({load_done, load_err, core_rst_n, busy} !== 4'b1010) begin
      errors++; $display("FAIL a85_status: got done/err/crn/busy=%b%b%b%b want 1010", load_done, load_err, core_rst_n, busy);
    end
  endtask

  // DONE must ignore further traffic, including another sync sequence.
  task automatic test_terminal();
    got_addr.delete(); got_data.delete();
    tx_bytes.delete(); tx_bad.delete();
    add(8'hA5); add(8'h01); add(8'h00); add(8'hAA); add(8'hBB); add(8'hCC); add(8'hDD);
    add_chk();
    send_all();
    checks++;
    if (got_addr.size() != 0 || {load_done, core_rst_n, busy} !== 3'b110) begin
      errors++;
      $display("FAIL terminal: got writes=%0d done/crn/busy=%b%b%b want 0 110", got_addr.size(), load_done, core_rst_n, busy);
    end
  endtask

  task automatic test_noise();
    do_reset();
    add(8'h00); add(8'hFF); add(8'h12);
    add(8'hA5); add(8'h01); add(8'h00); add(8'hEF); add(8'hBE); add(8'hAD); add(8'hDE);
    add_chk();
    run_model();
    send_all();
    checks++;
    if (got_addr.size() != 1 || got_data[0] !== 32'hDEADBEEF || got_addr[0] !== '0) begin
      errors++;
      $display("FAIL noise_write: got n=%0d first=%h want 1 deadbeef@0", got_addr.size(),
               (got_data.size() > 0) ? got_data[0] : 32'h0);
    end
    checks++;
    if ({load_done, load_err, core_rst_n, busy} !== {exp_done, exp_err, exp_done, 1'b0}) begin
      errors++; $display("FAIL noise_status: got %b%b%b%b want %b%b%b0", load_done, load_err, core_rst_n, busy, exp_done, exp_err, exp_done);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    add(8'hA5); add(8'h00); add(8'h00);
    add_chk();
    send_all();
    checks++;
    if (got_addr.size() != 0 || {load_done, load_err, core_rst_n, busy} !== 4'b1010) begin
      errors++;
      $display("FAIL zero_len: got writes=%0d status=%b%b%b%b want 0 1010", got_addr.size(), load_done, load_err, core_rst_n, busy);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_chk();
    do_reset();
    add(8'hA5); add(8'h01); add(8'h00); add(8'h01); add(8'h02); add(8'h03); add(8'h04); add(8'h00);
    run_model();
    send_all();
    checks++;
    if (got_data.size() != 1 || got_data[0] !== 32'h04030201) begin
      errors++; $display("FAIL bad_chk_write: got n=%0d want 1 word 04030201", got_data.size());
    end
    checks++;
    if ({load_done, load_err, core_rst_n, busy} !== {exp_done, exp_err, 2'b00}) begin
      errors++; $display("FAIL bad_chk_status: got %b%b%b%b want %b%b00", load_done, load_err, core_rst_n, busy, exp_done, exp_err);
    end
  endtask
`endif

  task automatic test_reset_mid_word();
    do_reset();
    add(8'hA5); add(8'h02); add(8'h00); add(8'h11); add(8'h22);
    send_all();
    checks++;
    if (busy !== 1'b1 || got_addr.size() != 0) begin
      errors++; $display("FAIL midword_busy: got busy=%b writes=%0d want 1 0", busy, got_addr.size());
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({imem_we, imem_addr, imem_wdata, core_rst_n, busy, load_done, load_err} !== '0 || got_addr.size() != 0) begin
      errors++;
      $display("FAIL midword_reset: got we=%b addr=%h wd=%h crn=%b busy=%b writes=%0d want zeros",
               imem_we, imem_addr, imem_wdata, core_rst_n, busy, got_addr.size());
    end
    do_reset();
    add(8'hA5); add(8'h01); add(8'h00); add(8'h78); add(8'h56); add(8'h34); add(8'h12);
    add_chk();
    run_model();
    send_all();
    checks++;
    if (got_addr.size() != 1 || got_addr[0] !== exp_addr[0] || got_data[0] !== exp_data[0] || load_done !== 1'b1) begin
      errors++;
      $display("FAIL midword_reload: got n=%0d done=%b want 1 word %h@%h done=1", got_addr.size(), load_done, exp_data[0], exp_addr[0]);
    end
  endtask

  task automatic test_framing();
    do_reset();
    add(8'hA5); add(8'h01); add(8'h00);
    add(8'h11); add(8'h22, 1'b1); add(8'h33); add(8'h44); add(8'h55);
    add_chk();
    run_model();
    send_all();
    checks++;
    if (got_data.size() != 1 || got_data[0] !== 32'h55443311) begin
      errors++;
      $display("FAIL framing_word: got n=%0d first=%h want 1 55443311", got_data.size(),
               (got_data.size() > 0) ? got_data[0] : 32'h0);
    end
    checks++;
    if ({load_done, core_rst_n, busy} !== {exp_done, exp_done, 1'b0}) begin
      errors++; $display("FAIL framing_status: got %b%b%b want %b%b0", load_done, core_rst_n, busy, exp_done, exp_done);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int nn, len;
      logic [7:0] b;
      do_reset();
      nn = $urandom_range(0, 3);
      for (int k = 0; k < nn; k++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        add(b);
      end
      len = $urandom_range(1, 3);
      add(8'hA5); add(8'(len)); add(8'h00);
      for (int k = 0; k < 4 * len; k++) add(8'($urandom_range(0, 255)));
      add_chk();
      run_model();
      send_all();
      checks++;
      if (got_addr.size() != exp_addr.size()) begin
        errors++; $display("FAIL rand%0d_wcount: got %0d want %0d", it, got_addr.size(), exp_addr.size());
      end
      for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
        checks++;
        if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
          errors++;
          $display("FAIL rand%0d_write%0d: got %h@%h want %h@%h", it, k, got_data[k], got_addr[k], exp_data[k], exp_addr[k]);
        end
      end
      checks++;
      if ({load_done, load_err, core_rst_n, busy} !== {exp_done, exp_err, exp_done, 1'b0}) begin
        errors++;
        $display("FAIL rand%0d_status: got %b%b%b%b want %b%b%b0", it, load_done, load_err, core_rst_n, busy, exp_done, exp_err, exp_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_a85();
    test_terminal();
    test_noise();
    test_zero_len();
`ifdef LOADER_CHECKSUM_EN
    test_bad_chk();
`endif
    test_reset_mid_word();
    test_framing();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_imem_loader
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL take the parameter CLKS_PER_BIT, default 868, meaning system clocks per UART bit (100 MHz / 115200).
REQ-002 The block SHALL take the parameter ADDR_W, default 20, meaning the instruction-memory word-address width (matches core fetch address).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have these signal ports:
- uart_rx  in  1  asynchronous serial line, idle high, 8N1.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address of the current write.
- imem_wdata  out  32  instruction word to write.
- core_rst_n  out  1  core reset, low while loading, high after a successful load.
- busy  out  1  high from sync byte accepted until DONE or ERROR.
- load_done  out  1  sticky, load completed successfully.
- load_err  out  1  sticky, checksum mismatch.

Function
REQ-005 The rx path SHALL pass uart_rx through a 2-FF synchronizer, detect the start bit on a falling edge, and sample each bit at mid-bit (CLKS_PER_BIT/2 after the start edge, then every CLKS_PER_BIT).
REQ-006 The rx path SHALL receive data LSB first and emit a 1-cycle rx_valid with rx_byte after the stop-bit sample; a low stop bit SHALL discard the byte (no rx_valid).
REQ-007 The FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERROR.
REQ-008 In IDLE, byte 8'hA5 SHALL transition to LEN_LO; all other bytes SHALL be ignored.
REQ-009 The word count SHALL be 16 bits, little-endian: LEN_LO then LEN_HI.
REQ-010 From LEN_HI, count 0 SHALL go to CHK (macro defined) or DONE (undefined); nonzero count SHALL go to DATA.
REQ-011 In DATA, words SHALL be assembled from 4 bytes, little-endian (first byte = bits 7:0).
REQ-012 imem_we SHALL pulse exactly one cycle, on the cycle after the 4th byte's rx_valid, with imem_wdata equal to the assembled word and imem_addr equal to the word index.
REQ-013 imem_addr SHALL start at 0 and increment by 1 on the cycle after each write; it SHALL NOT wrap, since the 16-bit count is below 2^ADDR_W.
REQ-014 After the last word's write, the FSM SHALL go to CHK (macro defined) or DONE (undefined).
REQ-015 DONE and ERROR SHALL be terminal until rst; rx bytes received in these states SHALL be ignored.
REQ-016 core_rst_n SHALL be registered, high only while state is DONE (first high one cycle after entering DONE).
REQ-017 load_done SHALL assert on DONE entry; load_err SHALL assert on ERROR entry.
REQ-018 The FSM SHALL advance at most one byte per rx_valid.

Reset
REQ-019 On rst the block SHALL set: state IDLE, rx path idle, imem_we 0, imem_addr 0, imem_wdata 0, core_rst_n 0, busy 0, load_done 0, load_err 0.
REQ-020 rst asserted mid-transfer SHALL abort the transfer and discard any partial byte or word without a write; no imem_we SHALL be issued in the reset cycle.

Configuration
REQ-021 With LOADER_CHECKSUM_EN defined, one byte SHALL follow the payload: the XOR of all length and data bytes. In CHK, a match SHALL go to DONE and a mismatch to ERROR (core_rst_n stays low).
REQ-022 With LOADER_CHECKSUM_EN undefined, the CHK state, XOR accumulator and ERROR entry SHALL be absent, and load_err SHALL be tied 0.

Structure
REQ-023 The shared package loader_pkg SHALL hold the FSM state encoding, SYNC_BYTE = 8'hA5 and LEN_W = 16.
REQ-024 The UART receiver SHALL be the sub-module loader_uart_rx (ports clk, rst, rx, rx_valid, rx_byte), instantiated once.

Verification
REQ-025 A85 sequence SHALL be covered: bytes A5 02 00 13 00 00 00 6F 00 00 00 (plus checksum 7E if enabled) -> writes addr0=32'h00000013, addr1=32'h0000006F; core_rst_n rises; load_done=1.
REQ-026 A noise-prefix case SHALL be covered: 00 FF 12 before A5 01 00 EF BE AD DE -> single write addr0=32'hDEADBEEF; the noise bytes cause no effect.
REQ-027 A zero-length case SHALL be covered: A5 00 00 (checksum 00 if enabled) -> no imem_we; DONE; core_rst_n=1.
REQ-028 A bad-checksum case (macro defined) SHALL be covered: A5 01 00 01 02 03 04 with checksum 00 instead of 05 -> word written, load_err=1, core_rst_n stays 0.
REQ-029 A reset-mid-word case SHALL be covered: rst asserted after 2 data bytes -> no write, all outputs at reset values; a fresh full sequence afterwards loads from addr 0.
REQ-030 A framing-error case SHALL be covered: a data byte sent with stop bit 0 -> byte dropped, word completes only after 4 valid bytes.
